// File: rtl/systolic_mm_engine.sv
// NxN output-stationary systolic array computing C = A*B from streamed column/row beats,
// with internal operand skew, optional accumulate-onto-previous and saturating sums.
module systolic_mm_engine #(
  parameter int N  = 8,
  parameter int DW = 8,
  parameter int AW = 32,
  parameter int KW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   acc_en,
  input  logic                   sat_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        a_vec,
  input  logic [N*DW-1:0]        b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*AW-1:0]        out_data,
  output logic [$clog2(N)-1:0]   out_row,
  output logic                   busy,
  output logic                   done
);
  // state    | meaning
  // S_IDLE   | waiting for start
  // S_LOAD   | accepting K operand beats
  // S_DRAIN  | flushing skew and array pipelines with zeros, 2N-1 cycles
  // S_OUTPUT | presenting result rows 0..N-1
  localparam int RW = $clog2(N);
  localparam int CW = $clog2(2*N);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_OUTPUT} state_t;

  state_t state_q, state_d;
  logic [KW-1:0] beat_cnt;
  logic [CW-1:0] drain_cnt;
  logic [RW-1:0] row_q;
  logic          sat_q, done_q;
  logic          start_acc, accept, clr_acc, row_last;

  logic signed [DW-1:0] inj_a [N];
  logic signed [DW-1:0] inj_b [N];
  logic signed [DW-1:0] a_sk  [N];
  logic signed [DW-1:0] b_sk  [N];
  logic signed [DW-1:0] a_h   [N][N-1];
  logic signed [DW-1:0] b_v   [N-1][N];
  logic signed [AW-1:0] acc   [N][N];

  assign row_last = (row_q == RW'(N-1));
  assign clr_acc  = start_acc && !acc_en;

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    accept    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (k_len == '0) ? S_OUTPUT : S_LOAD;
        end
      end
      S_LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept && beat_cnt == KW'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == '0) state_d = S_OUTPUT;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready && row_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      beat_cnt  <= '0;
      drain_cnt <= '0;
      row_q     <= '0;
      sat_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= out_valid && out_ready && row_last;
      if (start_acc) begin
        beat_cnt <= k_len;
        sat_q    <= sat_en;
      end else if (accept) begin
        beat_cnt <= beat_cnt - KW'(1);
      end
      // Down-counter is only nonzero during DRAIN; terminal count 0 ends it.
      if (accept && beat_cnt == KW'(1)) drain_cnt <= CW'(2*N-2);
      else if (drain_cnt != '0)         drain_cnt <= drain_cnt - CW'(1);
      if (out_valid && out_ready) row_q <= row_last ? '0 : row_q + RW'(1);
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign out_row = row_q;

  always_comb begin
    out_data = '0;
    for (int j = 0; j < N; j++) begin
      if (out_valid) out_data[j*AW +: AW] = acc[row_q][j];
    end
  end

  // Zeros enter whenever no beat is taken, so bubbles and idle cycles add nothing.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      inj_a[i] = accept ? a_vec[i*DW +: DW] : '0;
      inj_b[i] = accept ? b_vec[i*DW +: DW] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_sk[i] = inj_a[i];
      assign b_sk[i] = inj_b[i];
    end else begin : g_delay
      logic signed [DW-1:0] sa [i];
      logic signed [DW-1:0] sb [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < i; s++) begin
            sa[s] <= '0;
            sb[s] <= '0;
          end
        end else begin
          sa[0] <= inj_a[i];
          sb[0] <= inj_b[i];
          for (int s = 1; s < i; s++) begin
            sa[s] <= sa[s-1];
            sb[s] <= sb[s-1];
          end
        end
      end
      assign a_sk[i] = sa[i-1];
      assign b_sk[i] = sb[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic signed [DW-1:0]   a_in, b_in;
      logic signed [2*DW-1:0] prod;
      logic        [AW:0]     sum;
      logic signed [AW-1:0]   acc_nxt;

      if (j == 0) begin : g_a_edge
        assign a_in = a_sk[i];
      end else begin : g_a_hop
        assign a_in = a_h[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_sk[j];
      end else begin : g_b_hop
        assign b_in = b_v[i-1][j];
      end

      assign prod = (2*DW)'(a_in) * (2*DW)'(b_in);
      // One guard bit exposes overflow of the exact sum before wrapping or clamping.
      assign sum  = {acc[i][j][AW-1], acc[i][j]} + {{(AW+1-2*DW){prod[2*DW-1]}}, prod};

      always_comb begin
        acc_nxt = sum[AW-1:0];
        if (sat_q && (sum[AW] != sum[AW-1]))
          acc_nxt = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       acc[i][j] <= '0;
        else if (clr_acc) acc[i][j] <= '0;
        else              acc[i][j] <= acc_nxt;
      end

      if (j < N-1) begin : g_east
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) a_h[i][j] <= '0;
          else        a_h[i][j] <= a_in;
        end
      end
      if (i < N-1) begin : g_south
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) b_v[i][j] <= '0;
          else        b_v[i][j] <= b_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Bench for systolic_mm_engine: two instances (AW=32 and AW=16) share stimulus and are
// compared against a matrix-level reference model of C += A*B with wrap or clamp.
module tb_systolic_mm_engine;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int KW = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start, acc_en, sat_en, in_valid, out_ready;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] a_vec, b_vec;

  logic            in_ready, out_valid, busy, done;
  logic [N*32-1:0] out_data;
  logic [1:0]      out_row;
  logic            in_ready_w, out_valid_w, busy_w, done_w;
  logic [N*16-1:0] out_data_w;
  logic [1:0]      out_row_w;

  systolic_mm_engine #(.N(N), .DW(DW), .AW(32), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .acc_en(acc_en),
    .sat_en(sat_en), .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec),
    .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .busy(busy), .done(done));

  systolic_mm_engine #(.N(N), .DW(DW), .AW(16), .KW(KW)) dut_w16 (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .acc_en(acc_en),
    .sat_en(sat_en), .in_valid(in_valid), .in_ready(in_ready_w), .a_vec(a_vec),
    .b_vec(b_vec), .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_row(out_row_w), .busy(busy_w), .done(done_w));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     ta  [16][N];
  int     tbv [16][N];
  longint m32 [N][N];
  longint m16 [N][N];

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic longint fit(input longint v, input int aw, input bit sat);
    longint one  = 1;
    longint hi   = (one <<< (aw-1)) - 1;
    longint lo   = -(one <<< (aw-1));
    longint span = one <<< aw;
    longint r;
    if (sat) begin
      r = (v > hi) ? hi : (v < lo) ? lo : v;
    end else begin
      r = v & (span - 1);
      if (r > hi) r = r - span;
    end
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        m32[i][j] = 0;
        m16[i][j] = 0;
      end
  endtask

  task automatic model_beat(input int k, input bit sat);
    longint p;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        p = longint'(ta[k][i]) * longint'(tbv[k][j]);
        m32[i][j] = fit(m32[i][j] + p, 32, sat);
        m16[i][j] = fit(m16[i][j] + p, 16, sat);
      end
  endtask

  task automatic fill_const(input int k, input int av, input int bv);
    for (int b = 0; b < k; b++)
      for (int i = 0; i < N; i++) begin
        ta[b][i]  = av;
        tbv[b][i] = bv;
      end
  endtask

  task automatic fill_rand(input int k);
    for (int b = 0; b < k; b++)
      for (int i = 0; i < N; i++) begin
        ta[b][i]  = int'($urandom_range(0, 255)) - 128;
        tbv[b][i] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic check_row(input int r);
    check("row", out_row, r);
    check("row_w16", out_row_w, r);
    for (int j = 0; j < N; j++) begin
      check("c32", longint'($signed(out_data[j*32 +: 32])), m32[r][j]);
      check("c16", longint'($signed(out_data_w[j*16 +: 16])), m16[r][j]);
    end
  endtask

  // mode 0: stream every cycle, 1: valid pattern 1,0,1,1,0,1, 2: random valid plus stray starts
  task automatic run_op(input int k, input bit acc_e, input bit sat_e, input int mode,
                        input int hold_row, input bit chk_lat);
    int pat [6] = '{1, 0, 1, 1, 0, 1};
    int bi, step, c0, row_exp, held, budget;
    bit vld;
    @(negedge clk);
    check("idle_busy", busy, 0);
    start = 1'b1; k_len = KW'(k); acc_en = acc_e; sat_en = sat_e; out_ready = 1'b1;
    c0 = cyc;
    if (!acc_e) clear_model();
    bi = 0; step = 0; budget = 0;
    while (bi < k && budget < 200) begin
      @(negedge clk);
      budget++;
      start  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      k_len  = '0;
      acc_en = 1'b0;
      case (mode)
        0:       vld = 1'b1;
        1:       vld = (pat[step % 6] != 0);
        default: vld = ($urandom_range(0, 3) != 0);
      endcase
      step++;
      in_valid = vld;
      for (int i = 0; i < N; i++) begin
        a_vec[i*DW +: DW] = vld ? DW'(ta[bi][i])  : DW'($urandom);
        b_vec[i*DW +: DW] = vld ? DW'(tbv[bi][i]) : DW'($urandom);
      end
      if (in_valid && in_ready) begin
        model_beat(bi, sat_e);
        bi++;
      end
    end
    if (bi < k) check("load_timeout", bi, k);
    row_exp = 0; held = 0; budget = 0;
    while (row_exp < N && budget < 200) begin
      @(negedge clk);
      budget++;
      start = 1'b0; in_valid = 1'b0;
      if (out_valid) begin
        out_ready = !(row_exp == hold_row && held < 3);
        if (!out_ready) held++;
        check_row(row_exp);
        if (out_ready) row_exp++;
      end else begin
        out_ready = 1'b1;
        check("idle_data_zero", out_data, 0);
      end
    end
    if (row_exp < N) check("out_timeout", row_exp, N);
    out_ready = 1'b1;
    @(negedge clk);
    check("done", done, 1);
    check("done_w16", done_w, 1);
    check("busy_after", busy, 0);
    check("valid_after", out_valid, 0);
    if (chk_lat) check("latency", cyc - c0, k + (2*N-1) + N + 1);
    @(negedge clk);
    check("done_pulse", done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0; acc_en = 1'b0; sat_en = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a_vec = '0; b_vec = '0;
    clear_model();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Identity A, B[k][j] = 4k+j
    for (int b = 0; b < N; b++)
      for (int i = 0; i < N; i++) begin
        ta[b][i]  = (i == b) ? 1 : 0;
        tbv[b][i] = b*4 + i;
      end
    run_op(4, 0, 0, 0, -1, 1);

    fill_const(4, -128, -128);
    run_op(4, 0, 0, 0, -1, 1);

    fill_const(4, 127, 127);
    run_op(4, 0, 1, 0, -1, 1);
    run_op(4, 0, 0, 0, -1, 1);

    fill_const(2, 1, 1);
    run_op(2, 0, 0, 0, -1, 1);
    run_op(2, 1, 0, 0, -1, 1);
    run_op(2, 0, 0, 0, -1, 1);

    // Zero-length runs: retained sums, then cleared sums
    run_op(0, 1, 0, 0, -1, 0);
    run_op(0, 0, 0, 0, -1, 0);

    fill_rand(4);
    run_op(4, 0, 0, 1, 1, 0);

    for (int t = 0; t < 5; t++) begin
      int k;
      k = int'($urandom_range(1, 6));
      fill_rand(k);
      run_op(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2,
             int'($urandom_range(0, 4)) - 1, 0);
    end

    // Reset in the middle of LOAD after two accepted beats
    @(negedge clk);
    start = 1'b1; k_len = KW'(4); acc_en = 1'b0; sat_en = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b1;
      a_vec = $urandom; b_vec = $urandom;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_row", out_row, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_busy_w16", busy_w, 0);
    check("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    fill_const(1, 2, 2);
    run_op(1, 1, 0, 0, -1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_mm_engine.md
SYSTOLIC_MM_ENGINE -- requirements
Module: systolic_mm_engine

Interface
REQ-001 Parameters SHALL be as follows.
- N, default 8: array dimension; the array is NxN PEs and N>=2.
- DW, default 8: signed operand width.
- AW, default 32: signed accumulator width, with AW>=2*DW.
- KW, default 16: width of k_len.
REQ-002 Ports SHALL be as follows.
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: reset; asynchronous and active-low.
- start  in  1: one-cycle command pulse.
- k_len  in  KW: inner dimension K, sampled when start is accepted.
- acc_en  in  1: when 1, keep the existing sums and accumulate onto them; sampled at start.
- sat_en  in  1: when 1, clamp the accumulator on overflow; sampled at start.
- in_valid  in  1: operand beat valid.
- in_ready  out  1: engine accepts an operand beat.
- a_vec  in  N*DW: column k of A; element i sits at bits [i*DW +: DW].
- b_vec  in  N*DW: row k of B; element j sits at bits [j*DW +: DW].
- out_valid  out  1: result row valid.
- out_ready  in  1: consumer accepts a result row.
- out_data  out  N*AW: row r of C; element j sits at bits [j*AW +: AW].
- out_row  out  clog2(N): index r of the row on out_data.
- busy  out  1: high whenever the state is not IDLE.
- done  out  1: one-cycle pulse when the operation completes.

Function
REQ-003 The FSM SHALL have four states: IDLE, LOAD, DRAIN, OUTPUT.
REQ-004 IDLE SHALL go to LOAD on start when k_len>0, and directly to OUTPUT on start when k_len==0.
- start SHALL be ignored in every other state.
REQ-005 When start is accepted with acc_en=0, all N*N accumulators SHALL clear on that same edge; with acc_en=1 they SHALL be retained.
REQ-006 in_ready SHALL equal 1 only in LOAD; a beat is accepted on a cycle where in_valid and in_ready are both 1.
REQ-007 The engine SHALL skew operands internally.
- a element i is delayed i cycles and b element j is delayed j cycles before entering the array.
- The host supplies unskewed vectors.
REQ-008 Each PE(i,j) SHALL register its a input to its east neighbour and its b input to its south neighbour, one cycle per hop.
- Each PE adds the signed product a*b, sign-extended to AW, to acc[i][j] every cycle.
REQ-009 In any LOAD cycle with no accepted beat, zeros SHALL be injected at the skew inputs.
- Bubbles therefore do not change the result.
REQ-010 LOAD SHALL go to DRAIN on the edge that accepts beat K-1.
REQ-011 DRAIN SHALL last exactly 2N-1 cycles while zeros are injected, then go to OUTPUT.
- At that point every product of every accepted beat is in acc.
REQ-012 Accumulation mode SHALL be chosen by sat_en.
- sat_en=0: two's-complement wrap modulo 2^AW.
- sat_en=1: clamp to [-2^(AW-1), 2^(AW-1)-1] whenever the exact sum leaves that range.
REQ-013 In OUTPUT the engine SHALL present rows r=0..N-1 in order.
- out_valid=1, out_row=r and out_data=acc[r][*] are held stable until out_ready=1.
- r advances by one on each handshake.
REQ-014 The handshake on row N-1 SHALL go to IDLE and assert done for exactly the following cycle.
- Accumulators are retained for a later acc_en=1 run.
REQ-015 out_valid SHALL be 0 outside OUTPUT, and out_data SHALL be 0 when out_valid=0.
REQ-016 The start-to-done time SHALL be K + (2N-1) + N + 1 cycles when operands stream every cycle and out_ready is held at 1.

Reset
REQ-017 rst_n low SHALL asynchronously force the following, in any state including mid-LOAD, mid-DRAIN and mid-OUTPUT:
- FSM to IDLE;
- all accumulators, skew registers and PE pipeline registers to 0;
- row counter and beat counter to 0;
- in_ready=0, out_valid=0, out_data=0, out_row=0, busy=0, done=0.
REQ-018 After rst_n deasserts, the first start SHALL behave as if acc_en=0, because the accumulators are already 0.

Verification
Scenarios use N=4, DW=8, AW=32 unless stated otherwise.
REQ-019 Identity: K=4, A=I, B[k][j]=k*4+j, sat_en=0 -> rows out as C=B; done 4+7+4+1=16 cycles after start.
REQ-020 Signed extreme: K=4, all a=-128, all b=-128 -> every out_data element is 65536.
REQ-021 Saturation: AW=16, K=4, all operands 127 (exact sum 64516):
- sat_en=1 -> every element is 32767;
- sat_en=0 -> every element is -1020.
REQ-022 Accumulate, all operands 1, K=2:
- run 1 with acc_en=0 -> every element 2;
- run 2 with acc_en=1 -> every element 4;
- run 3 with acc_en=0 -> every element 2.
REQ-023 Flow control:
- in_valid pattern 1,0,1,1,0,1 for K=4 with random data -> C matches the reference model;
- out_ready low for 3 cycles on row 1 -> out_data and out_row held, then row 1 is delivered exactly once.
REQ-024 Reset mid-LOAD after 2 beats -> all outputs 0 and busy=0 immediately; a following K=1 run with all operands 2 outputs 4 in every element.
